data_mem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port 256x16 data RAM between the CPU16 core (port 0) and an I/O/DMA requester (port 1). It latches one request at a time, sequences the RAM's synchronous address capture and unregistered read output, and returns read data with a one-cycle acknowledge pulse. It sits between the requesters and the data RAM and is the only agent driving the RAM address, write-enable and write-data pins.

---
 rtl/data_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port 256x16 data RAM between the CPU16
// core (port 0) and the I/O/DMA requester (port 1), one access at a time.
// Each access is IDLE -> ACCESS -> RESP -> IDLE: the request is latched at
// E0, the RAM captures the address at E1, read data is captured at E2 and
// the owner's ack is high in the cycle after E2.
//
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata           CPU completion pulse and registered read data
//   io_req/we/addr/wdata         I/O request (held until io_ack)
//   io_ack, io_rdata             I/O completion pulse and registered read data
//   mem_addr/we/wdata, mem_rdata RAM pins (sync address capture, async output)
//   busy                         high whenever the FSM is not IDLE
//
// Build option: define DATA_MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise the CPU wins every tie.

module data_mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        io_req,
  input  logic        io_we,
  input  logic [7:0]  io_addr,
  input  logic [15:0] io_wdata,
  output logic        io_ack,
  output logic [15:0] io_rdata,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        owner_q, owner_d;       // 0 = CPU, 1 = I/O
  logic        cpu_ack_q, cpu_ack_d;
  logic        io_ack_q, io_ack_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] io_rdata_q, io_rdata_d;

  logic        cpu_elig;
  logic        io_elig;
  logic        grant_any;
  logic        grant_io;

  // A port whose ack is high is still holding req for the access that just
  // finished, so it is masked to avoid a duplicate grant.
  assign cpu_elig  = cpu_req & ~cpu_ack_q;
  assign io_elig   = io_req  & ~io_ack_q;
  assign grant_any = cpu_elig | io_elig;

`ifdef DATA_MEM_ARB_RR_EN
  // ptr_q names the port favoured on the next tie (0 = CPU, 1 = I/O).
  logic ptr_q, ptr_d;

  assign grant_io = io_elig & (~cpu_elig | ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && grant_any) begin
      ptr_d = ~grant_io;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign grant_io = io_elig & ~cpu_elig;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    cpu_ack_d   = 1'b0;
    io_ack_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          state_d = ST_ACCESS;
          owner_d = grant_io;
          if (grant_io) begin
            we_d    = io_we;
            addr_d  = io_addr;
            wdata_d = io_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // RAM output reflects the address captured at the previous edge.
        state_d = ST_IDLE;
        if (owner_q) begin
          io_ack_d = 1'b1;
          if (!we_q) begin
            io_rdata_d = mem_rdata;
          end
        end else begin
          cpu_ack_d = 1'b1;
          if (!we_q) begin
            cpu_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 16'h0000;
      owner_q     <= 1'b0;
      cpu_ack_q   <= 1'b0;
      io_ack_q    <= 1'b0;
      cpu_rdata_q <= 16'h0000;
      io_rdata_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      cpu_ack_q   <= cpu_ack_d;
      io_ack_q    <= io_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
    end
  end

  // mem_we decodes straight from state so it falls the instant reset rises.
  assign mem_we    = (state_q == ST_ACCESS) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign cpu_ack   = cpu_ack_q;
  assign io_ack    = io_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign io_rdata  = io_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 256x16 RAM
// (address captured on the clock edge, unregistered read output).
module tb_data_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [7:0]  cpu_addr, io_addr;
  logic [15:0] cpu_wdata, io_wdata;
  logic        cpu_ack, io_ack, mem_we, busy;
  logic [15:0] cpu_rdata, io_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;

  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_dat;
  logic [15:0] ram [256];
  logic [7:0]  ram_raddr;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] io_rd_exp;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pre_en) ram[pre_addr] <= pre_dat;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    ram_raddr <= mem_addr;
  end
  assign mem_rdata = ram[ram_raddr];

  data_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_en = 1'b1; pre_addr = a; pre_dat = d;
    step();
    pre_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
    io_req = 1'b0; io_we = 1'b0; io_addr = 8'h00; io_wdata = 16'h0000;
    pre_en = 1'b0; pre_addr = 8'h00; pre_dat = 16'h0000;
    step(); step();

    // Reset values
    chk("rst_busy", busy, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_io_ack", io_ack, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
    chk("rst_io_rdata", io_rdata, 16'h0000);

    preload(8'h10, 16'hBEEF);
    preload(8'hFF, 16'h0F0F);
    preload(8'h20, 16'hAAAA);
    reset = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // Tie 1 (pointer at reset favours the CPU): CPU wins in both builds
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    io_req = 1'b1; io_we = 1'b0; io_addr = 8'hFF;
    step();
    chk("tie1_addr", mem_addr, 16'h0010);
    chk("tie1_busy", busy, 1);
    cpu_req = 1'b0; io_req = 1'b0;
    step(); step();
    chk("tie1_cpu_ack", cpu_ack, 1);
    chk("tie1_io_ack", io_ack, 0);
    chk("tie1_cpu_rdata", cpu_rdata, 16'hBEEF);
    step();

    // Tie 2: round-robin now favours I/O; fixed priority still picks CPU
    cpu_req = 1'b1; io_req = 1'b1;
    step();
`ifdef DATA_MEM_ARB_RR_EN
    chk("tie2_addr", mem_addr, 16'h00FF);
    io_rd_exp = 16'h0F0F;
`else
    chk("tie2_addr", mem_addr, 16'h0010);
    io_rd_exp = 16'h0000;
`endif
    cpu_req = 1'b0; io_req = 1'b0;
    step(); step();
`ifdef DATA_MEM_ARB_RR_EN
    chk("tie2_cpu_ack", cpu_ack, 0);
    chk("tie2_io_ack", io_ack, 1);
`else
    chk("tie2_cpu_ack", cpu_ack, 1);
    chk("tie2_io_ack", io_ack, 0);
`endif
    chk("tie2_io_rdata", io_rdata, io_rd_exp);
    step();

    // CPU read of 0x10
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    step();
    chk("rd_e0_we", mem_we, 0);
    chk("rd_e0_busy", busy, 1);
    chk("rd_e0_ack", cpu_ack, 0);
    step();
    chk("rd_e1_we", mem_we, 0);
    chk("rd_e1_ack", cpu_ack, 0);
    step();
    chk("rd_e2_ack", cpu_ack, 1);
    chk("rd_e2_rdata", cpu_rdata, 16'hBEEF);
    chk("rd_e2_io_ack", io_ack, 0);
    cpu_req = 1'b0;
    step();
    chk("rd_e3_ack", cpu_ack, 0);

    // I/O write of 0x1234 to 0xFF
    io_req = 1'b1; io_we = 1'b1; io_addr = 8'hFF; io_wdata = 16'h1234;
    step();
    chk("wr_e0_we", mem_we, 1);
    chk("wr_e0_addr", mem_addr, 16'h00FF);
    chk("wr_e0_wdata", mem_wdata, 16'h1234);
    step();
    chk("wr_e1_we", mem_we, 0);
    chk("wr_e1_addr", mem_addr, 16'h00FF);
    step();
    chk("wr_io_ack", io_ack, 1);
    chk("wr_io_rdata_kept", io_rdata, io_rd_exp);
    io_req = 1'b0; io_we = 1'b0;
    step();

    // CPU read-back of 0xFF
    cpu_req = 1'b1; cpu_addr = 8'hFF;
    step(); step(); step();
    chk("rb_ack", cpu_ack, 1);
    chk("rb_rdata", cpu_rdata, 16'h1234);
    cpu_req = 1'b0;
    step();

    // Request dropped and address changed right after acceptance
    cpu_req = 1'b1; cpu_addr = 8'h10;
    step();
    cpu_req = 1'b0; cpu_addr = 8'h33;
    step();
    chk("drop_addr", mem_addr, 16'h0010);
    step();
    chk("drop_ack", cpu_ack, 1);
    chk("drop_rdata", cpu_rdata, 16'hBEEF);
    step();
    chk("drop_ack_fall", cpu_ack, 0);
    chk("drop_busy", busy, 0);

    // req held through ack: no grant while ack is high, regrant one edge later
    cpu_req = 1'b1; cpu_addr = 8'hFF;
    step(); step(); step();
    chk("hold_ack", cpu_ack, 1);
    chk("hold_rdata", cpu_rdata, 16'h1234);
    step();
    chk("hold_no_dup_busy", busy, 0);
    chk("hold_ack_fall", cpu_ack, 0);
    step();
    chk("hold_regrant_busy", busy, 1);
    cpu_req = 1'b0;
    step(); step();
    chk("hold_ack2", cpu_ack, 1);
    step();
    chk("hold_ack2_fall", cpu_ack, 0);

    // Both ports requesting continuously. The holder of a high ack is masked
    // at the next accept edge, so the other port wins alone: the ports
    // alternate in either build, starting with the CPU after reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    io_req = 1'b1; io_we = 1'b0; io_addr = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("cont_addr", mem_addr, (k % 2 == 0) ? 16'h0010 : 16'h00FF);
      step(); step();
      chk("cont_cpu_ack", cpu_ack, (k % 2 == 0) ? 16'h0001 : 16'h0000);
      chk("cont_io_ack", io_ack, (k % 2 == 0) ? 16'h0000 : 16'h0001);
    end
    chk("cont_cpu_rdata", cpu_rdata, 16'hBEEF);
    chk("cont_io_rdata", io_rdata, 16'h1234);
    cpu_req = 1'b0; io_req = 1'b0;
    step();

    // Reset asserted during ACCESS of a write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 16'h5555;
    step();
    chk("rstw_we_before", mem_we, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstw_we_async", mem_we, 0);
    chk("rstw_busy_async", busy, 0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rstw_cpu_ack", cpu_ack, 0);
    chk("rstw_io_ack", io_ack, 0);
    chk("rstw_busy", busy, 0);
    cpu_req = 1'b1; cpu_addr = 8'h20;
    step(); step(); step();
    chk("rstw_word_kept", cpu_rdata, 16'hAAAA);
    cpu_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
